jtag_loader: RTL and testbench

JTAG_LOADER -- requirements
Module: jtag_loader

---
 rtl/jtag_loader_pkg.sv | 27 ++
 rtl/jtag_loader_if.sv | 27 ++
 rtl/jtag_byte_port.sv | 84 ++++++++
 rtl/jtag_loader.sv | 150 +++++++++++++++
 tb/tb_jtag_loader.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_loader_pkg.sv
// Shared types and widths for the JTAG-to-SDRAM loader.
package jtag_loader_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;
    localparam int LEN_W        = 16;

    // Frame-level loader states
    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        SDRAM_WR,
        ACK,
        DONE
    } state_t;

    // Byte-level JTAG handshake states
    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_RD,
        PORT_CAP,
        PORT_WR
    } port_state_t;

endpackage

// File: rtl/jtag_loader_if.sv
// JTAG UART handshake plus SDRAM write request bus for jtag_loader.
interface jtag_loader_if;

    logic                                    Act;
    logic                                    WE;
    logic                                    R;
    logic                                    A;
    logic [7:0]                              Din;
    logic [7:0]                              Dout;
    logic                                    wr_valid;
    logic                                    wr_ready;
    logic [jtag_loader_pkg::SDRAM_ADDR_W-1:0] wr_addr;
    logic [jtag_loader_pkg::SDRAM_DATA_W-1:0] wr_data;
    logic                                    busy;
    logic                                    done;

    modport master (
        output Act, WE, Din, wr_valid, wr_addr, wr_data, busy, done,
        input  R, A, Dout, wr_ready
    );

    modport slave (
        input  Act, WE, Din, wr_valid, wr_addr, wr_data, busy, done,
        output R, A, Dout, wr_ready
    );

endinterface

// File: rtl/jtag_byte_port.sv
// Single-byte JTAG UART handshake: issues a read (get) or write (put) when
// A=1, holds Act until R=0, captures Dout one cycle after read completion.
// PUT_EN=0 ties WE and Din to zero.
module jtag_byte_port
    import jtag_loader_pkg::*;
#(
    parameter bit PUT_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       get,
    input  logic       put,
    input  logic [7:0] put_data,
    output logic       Act,
    output logic       WE,
    output logic [7:0] Din,
    input  logic       R,
    input  logic       A,
    input  logic [7:0] Dout,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       put_done
);

    port_state_t pstate;
    logic        we_q;
    logic [7:0]  din_q;

    // Handshake sequencer; no new request is issued in the cycle a result
    // pulse is visible, so the parent FSM has time to leave its state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pstate     <= PORT_IDLE;
            Act        <= 1'b0;
            we_q       <= 1'b0;
            din_q      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            put_done   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            put_done   <= 1'b0;
            case (pstate)
                PORT_IDLE: begin
                    if (A && !byte_valid && !put_done) begin
                        if (put && PUT_EN) begin
                            Act    <= 1'b1;
                            we_q   <= 1'b1;
                            din_q  <= put_data;
                            pstate <= PORT_WR;
                        end else if (get) begin
                            Act    <= 1'b1;
                            we_q   <= 1'b0;
                            pstate <= PORT_RD;
                        end
                    end
                end
                PORT_RD: begin
                    if (!R) begin
                        Act    <= 1'b0;
                        pstate <= PORT_CAP;
                    end
                end
                PORT_CAP: begin
                    byte_valid <= 1'b1;
                    byte_data  <= Dout;
                    pstate     <= PORT_IDLE;
                end
                PORT_WR: begin
                    if (!R) begin
                        Act      <= 1'b0;
                        put_done <= 1'b1;
                        pstate   <= PORT_IDLE;
                    end
                end
                default: pstate <= PORT_IDLE;
            endcase
        end
    end

    assign WE  = PUT_EN ? we_q  : 1'b0;
    assign Din = PUT_EN ? din_q : '0;

endmodule

// File: rtl/jtag_loader.sv
// JTAG-to-SDRAM loader: receives a length-prefixed frame of 16-bit words
// over the JTAG UART and writes them to consecutive SDRAM word addresses.
// Optional macro JTAG_LOADER_CHECKSUM_EN returns an 8-bit payload checksum.
module jtag_loader
    import jtag_loader_pkg::*;
#(
    parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR = 25'h0000000
) (
    input logic           Clk,
    input logic           Reset,
    jtag_loader_if.master bus
);

`ifdef JTAG_LOADER_CHECKSUM_EN
    localparam state_t FINISH = ACK;
    localparam bit     PUT_EN = 1'b1;
    logic [7:0] csum;
`else
    localparam state_t FINISH = DONE;
    localparam bit     PUT_EN = 1'b0;
`endif

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       lo_byte;
    logic             get;
    logic             put;
    logic [7:0]       put_data;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             put_done;

    assign get = (state == LEN_LO) || (state == LEN_HI) ||
                 (state == DATA_LO) || (state == DATA_HI);
    assign put = (state == ACK);
`ifdef JTAG_LOADER_CHECKSUM_EN
    assign put_data = csum;
`else
    assign put_data = '0;
`endif

    jtag_byte_port #(.PUT_EN(PUT_EN)) u_port (
        .Clk        (Clk),
        .Reset      (Reset),
        .get        (get),
        .put        (put),
        .put_data   (put_data),
        .Act        (bus.Act),
        .WE         (bus.WE),
        .Din        (bus.Din),
        .R          (bus.R),
        .A          (bus.A),
        .Dout       (bus.Dout),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .put_done   (put_done)
    );

    // Frame FSM with registered SDRAM request, busy and done outputs.
    // FINISH is ACK or DONE depending on whether the checksum is returned;
    // done is raised on the same edge that enters DONE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= LEN_LO;
            len          <= '0;
            cnt          <= '0;
            lo_byte      <= '0;
            bus.wr_valid <= 1'b0;
            bus.wr_addr  <= BASE_ADDR;
            bus.wr_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
`ifdef JTAG_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                LEN_LO: begin
                    if (byte_valid) begin
                        len[7:0] <= byte_data;
                        bus.busy <= 1'b1;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (byte_valid) begin
                        len[15:8]   <= byte_data;
                        cnt         <= '0;
                        bus.wr_addr <= BASE_ADDR;
`ifdef JTAG_LOADER_CHECKSUM_EN
                        csum        <= '0;
`endif
                        if ({byte_data, len[7:0]} == '0) begin
                            state    <= FINISH;
                            bus.done <= (FINISH == DONE);
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                DATA_LO: begin
                    if (byte_valid) begin
                        lo_byte <= byte_data;
`ifdef JTAG_LOADER_CHECKSUM_EN
                        csum    <= csum + byte_data;
`endif
                        state   <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (byte_valid) begin
                        bus.wr_data  <= {byte_data, lo_byte};
                        bus.wr_valid <= 1'b1;
`ifdef JTAG_LOADER_CHECKSUM_EN
                        csum         <= csum + byte_data;
`endif
                        state        <= SDRAM_WR;
                    end
                end
                SDRAM_WR: begin
                    if (bus.wr_ready) begin
                        bus.wr_valid <= 1'b0;
                        bus.wr_addr  <= bus.wr_addr + 25'd1;
                        cnt          <= cnt + 16'd1;
                        if (cnt == len - 16'd1) begin
                            state    <= FINISH;
                            bus.done <= (FINISH == DONE);
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                ACK: begin
                    if (put_done) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= LEN_LO;
                end
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_loader.sv
// Self-checking bench for jtag_loader: a JTAG UART host model with random
// busy cycles feeds frames; a scoreboard checks SDRAM writes, checksum and
// done for two instances (BASE_ADDR 0 and 25'h1FFFFFF, driven identically).
module tb_jtag_loader;
    import jtag_loader_pkg::*;

`ifdef JTAG_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][15:0] w;
        logic [7:0]       ck;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    jtag_loader_if j_if ();
    jtag_loader_if w_if ();

    jtag_loader #(.BASE_ADDR(25'h0000000)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (j_if.master)
    );

    jtag_loader #(.BASE_ADDR(25'h1FFFFFF)) dut_w (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (w_if.master)
    );

    assign w_if.R        = j_if.R;
    assign w_if.A        = j_if.A;
    assign w_if.Dout     = j_if.Dout;
    assign w_if.wr_ready = j_if.wr_ready;

    int unsigned nvec = 0;
    int unsigned nfail = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned rd_cnt = 0;
    int unsigned last_acc_cyc = 0;
    int unsigned busy_left = 0;
    bit          frame_wrote = 1'b0;
    bit          a_off = 1'b0;
    bit          ready_low = 1'b0;
    bit          pending_rd = 1'b0;
    bit          in_op = 1'b0;
    logic        act_prev = 1'b0;
    logic        we_prev = 1'b0;
    logic        a_prev = 1'b0;

    logic [7:0] host_q[$];
    wr_t        exp0_q[$];
    wr_t        exp1_q[$];
    logic [7:0] exp_ck_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        nvec++;
        nfail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // JTAG UART host, SDRAM responder and protocol/scoreboard monitor
    always @(negedge Clk) begin
        wr_t e;
        cyc++;
        if (Reset) begin
            pending_rd  = 1'b0;
            in_op       = 1'b0;
            frame_wrote = 1'b0;
            host_q.delete();
            exp0_q.delete();
            exp1_q.delete();
            exp_ck_q.delete();
            j_if.R        = 1'b1;
            j_if.A        = 1'b0;
            j_if.wr_ready = 1'b0;
            j_if.Dout     = 8'($urandom);
            act_prev      = 1'b0;
            a_prev        = 1'b0;
        end else begin
            // protocol checks on the outputs of the last edge
            if (j_if.Act && !act_prev) chk("act_issue_with_A", 32'(a_prev), 1);
            if (j_if.Act && act_prev)  chk("we_stable", 32'(j_if.WE), 32'(we_prev));
            if (j_if.wr_valid)         chk("no_act_in_sdram_wr", 32'(j_if.Act), 0);
            if (j_if.done) begin
                done_cnt++;
`ifndef JTAG_LOADER_CHECKSUM_EN
                if (frame_wrote) chk("done_after_last_accept", cyc, last_acc_cyc + 1);
`endif
                frame_wrote = 1'b0;
            end
            // read data appears the cycle after completion, garbage otherwise
            if (pending_rd) begin
                pending_rd = 1'b0;
                if (host_q.size() == 0) fail_now("read_underflow", "got read with empty host queue, expected no read");
                else j_if.Dout = host_q.pop_front();
            end else begin
                j_if.Dout = 8'($urandom);
            end
            // drive inputs for the coming edge
            if (j_if.Act) begin
                if (!in_op) begin
                    in_op     = 1'b1;
                    busy_left = $urandom_range(0, 3);
                end
                if (busy_left > 0) begin
                    j_if.R = 1'b1;
                    busy_left--;
                end else begin
                    j_if.R = 1'b0;
                    in_op  = 1'b0;
                end
            end else begin
                in_op  = 1'b0;
                j_if.R = 1'($urandom_range(0, 1));
            end
            j_if.A = !a_off && ($urandom_range(0, 3) != 0) &&
                     (host_q.size() != 0 || exp_ck_q.size() != 0);
            j_if.wr_ready = ready_low ? 1'b0 : 1'($urandom_range(0, 1));
            // events that complete on the coming edge
            if (j_if.Act && !j_if.R) begin
                if (j_if.WE) begin
`ifdef JTAG_LOADER_CHECKSUM_EN
                    if (exp_ck_q.size() == 0) fail_now("jtag_write", "got unexpected checksum write, expected none");
                    else chk("checksum_byte", 32'(j_if.Din), 32'(exp_ck_q.pop_front()));
`else
                    fail_now("jtag_write", "got JTAG write, expected none without checksum");
`endif
                end else begin
                    pending_rd = 1'b1;
                    rd_cnt++;
`ifndef JTAG_LOADER_CHECKSUM_EN
                    chk("we_const0", 32'(j_if.WE), 0);
                    chk("din_const0", 32'(j_if.Din), 0);
`endif
                end
            end
            if (j_if.wr_valid && j_if.wr_ready) begin
                last_acc_cyc = cyc;
                frame_wrote  = 1'b1;
                if (exp0_q.size() == 0) fail_now("sdram_write", "got unexpected write, expected none");
                else begin
                    e = exp0_q.pop_front();
                    chk("wr_addr", 32'(j_if.wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(j_if.wr_data), 32'(e.data));
                end
            end
            if (w_if.wr_valid && w_if.wr_ready) begin
                if (exp1_q.size() == 0) fail_now("sdram_write_w", "got unexpected write, expected none");
                else begin
                    e = exp1_q.pop_front();
                    chk("wr_addr_w", 32'(w_if.wr_addr), 32'(e.addr));
                    chk("wr_data_w", 32'(w_if.wr_data), 32'(e.data));
                end
            end
            act_prev = j_if.Act;
            we_prev  = j_if.WE;
            a_prev   = j_if.A;
        end
    end

    task automatic push_frame(input logic [15:0] ws[$], input logic [7:0] ck);
        logic [15:0] n;
        wr_t         e;
        n = 16'(ws.size());
        host_q.push_back(n[7:0]);
        host_q.push_back(n[15:8]);
        foreach (ws[k]) begin
            host_q.push_back(ws[k][7:0]);
            host_q.push_back(ws[k][15:8]);
            e.data = ws[k];
            e.addr = 25'(k);
            exp0_q.push_back(e);
            e.addr = 25'h1FFFFFF + 25'(k);
            exp1_q.push_back(e);
        end
        if (CK_EN) exp_ck_q.push_back(ck);
    endtask

    task automatic push_vec(input vec_t v);
        logic [15:0] ws[$];
        for (int k = 0; k < int'(v.n); k++) ws.push_back(v.w[k]);
        push_frame(ws, v.ck);
    endtask

    task automatic wait_done(input string name);
        int unsigned start = done_cnt;
        int unsigned t = 0;
        while (done_cnt == start && t < 20000) begin
            @(negedge Clk);
            t++;
        end
        repeat (3) @(negedge Clk);
        chk({name, "_done_pulses"}, done_cnt - start, 1);
        chk({name, "_writes_left"}, 32'(exp0_q.size()), 0);
        chk({name, "_writes_left_w"}, 32'(exp1_q.size()), 0);
        chk({name, "_bytes_left"}, 32'(host_q.size()), 0);
        chk({name, "_ck_left"}, 32'(exp_ck_q.size()), 0);
        chk({name, "_busy_idle"}, 32'(j_if.busy), 0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_act"}, 32'(j_if.Act), 0);
        chk({name, "_we"}, 32'(j_if.WE), 0);
        chk({name, "_din"}, 32'(j_if.Din), 0);
        chk({name, "_wr_valid"}, 32'(j_if.wr_valid), 0);
        chk({name, "_wr_addr"}, 32'(j_if.wr_addr), 32'h0000000);
        chk({name, "_wr_addr_w"}, 32'(w_if.wr_addr), 32'h1FFFFFF);
        chk({name, "_wr_data"}, 32'(j_if.wr_data), 0);
        chk({name, "_busy"}, 32'(j_if.busy), 0);
        chk({name, "_done"}, 32'(j_if.done), 0);
    endtask

    initial begin
        vec_t        vt[4];
        logic [15:0] ws[$];
        logic [15:0] w;
        logic [7:0]  ck;
        logic [24:0] sa;
        logic [15:0] sd;
        int unsigned start;
        int unsigned t;

        vt[0] = '{n: 3'd2, w: {16'h0000, 16'h0000, 16'h5678, 16'h1234}, ck: 8'h14};
        vt[1] = '{n: 3'd0, w: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, ck: 8'h00};
        vt[2] = '{n: 3'd1, w: {16'h0000, 16'h0000, 16'h0000, 16'hBBAA}, ck: 8'h65};
        vt[3] = '{n: 3'd3, w: {16'h0000, 16'h0A0B, 16'hFFFF, 16'h0102}, ck: 8'h16};

        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk_reset("reset");
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 4; i++) begin
            push_vec(vt[i]);
            wait_done("vec");
        end

        // SDRAM stall during word 0
        ready_low = 1'b1;
        @(negedge Clk);
        push_vec(vt[0]);
        t = 0;
        while (!j_if.wr_valid && t < 2000) begin
            @(negedge Clk);
            t++;
        end
        chk("stall_valid_seen", 32'(j_if.wr_valid), 1);
        chk("stall_addr", 32'(j_if.wr_addr), 0);
        chk("stall_data", 32'(j_if.wr_data), 32'h1234);
        chk("stall_busy", 32'(j_if.busy), 1);
        sa = j_if.wr_addr;
        sd = j_if.wr_data;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            chk("stall_valid_held", 32'(j_if.wr_valid), 1);
            chk("stall_addr_held", 32'(j_if.wr_addr), 32'(sa));
            chk("stall_data_held", 32'(j_if.wr_data), 32'(sd));
            chk("stall_act_low", 32'(j_if.Act), 0);
        end
        ready_low = 1'b0;
        wait_done("stall");

        // A held low: no request may be issued
        a_off = 1'b1;
        @(negedge Clk);
        push_vec(vt[3]);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("a_off_act_low", 32'(j_if.Act), 0);
        end
        chk("a_off_busy_low", 32'(j_if.busy), 0);
        a_off = 1'b0;
        wait_done("a_off");

        // Reset after three payload bytes, then a fresh one-word frame
        start = rd_cnt;
        push_vec(vt[0]);
        t = 0;
        while (rd_cnt < start + 5 && t < 2000) begin
            @(negedge Clk);
            t++;
        end
        chk("midframe_reads", rd_cnt - start, 5);
        repeat (3) @(negedge Clk);
        ready_low = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk_reset("midreset");
        Reset = 1'b0;
        ready_low = 1'b0;
        repeat (5) @(negedge Clk);
        push_vec(vt[2]);
        wait_done("after_reset");

        // Long frame: length high byte in use
        ck = 8'h00;
        for (int k = 0; k < 257; k++) begin
            w = 16'(k * 259 + 23);
            ws.push_back(w);
            ck = ck + w[7:0] + w[15:8];
        end
        push_frame(ws, ck);
        wait_done("long");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
